alu_cmd_sequencer: RTL and testbench

Command-driven initiator for the 8-bit ALU: accepts operation commands over a valid/ready handshake, reads two operands from an internal 8×8-bit register file, drives the ALU's A/B/ALU_Sel inputs, captures ALU_Out/Zero, optionally writes the result back, and returns it on a response handshake. It sits between the control path and the combinational ALU, which it instantiates externally (ALU ports brought out) so the ALU stays a standalone block.

---
 rtl/alu_cmd_sequencer_pkg.sv | 23 ++
 rtl/alu_cmd_sequencer_if.sv | 59 +++++
 rtl/alu_8_bit.sv | 29 ++
 rtl/alu_cmd_sequencer_regfile.sv | 34 +++
 rtl/alu_cmd_sequencer.sv | 118 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 6 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: opcode encodings,
// sequencer state encoding and datapath widths.
package alu_pkg;

   localparam int REG_AW = 3;
   localparam int DATA_W = 8;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_NOT = 3'd5;
   localparam logic [2:0] ALU_SHL = 3'd6;
   localparam logic [2:0] ALU_SHR = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, load, response and ALU-side signals of the sequencer.
// The slave modport is the sequencer; master is the controlling side.
interface alu_cmd_sequencer_if #(
   parameter int CNT_W = 16
);
   import alu_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [REG_AW-1:0] cmd_rs1;
   logic [REG_AW-1:0] cmd_rs2;
   logic [REG_AW-1:0] cmd_rd;
   logic              cmd_wr_en;

   logic              ld_valid;
   logic              ld_ready;
   logic [REG_AW-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;

   logic [DATA_W-1:0] ALU_A;
   logic [DATA_W-1:0] ALU_B;
   logic [2:0]        ALU_Sel;
   logic [DATA_W-1:0] ALU_Out;
   logic              ALU_Zero;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_zero;

   logic [CNT_W-1:0]  op_count;
   logic              busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wr_en,
      output cmd_ready,
      input  ld_valid, ld_addr, ld_data,
      output ld_ready,
      output ALU_A, ALU_B, ALU_Sel,
      input  ALU_Out, ALU_Zero,
      output rsp_valid, rsp_data, rsp_zero,
      input  rsp_ready,
      output op_count, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wr_en,
      input  cmd_ready,
      output ld_valid, ld_addr, ld_data,
      input  ld_ready,
      input  ALU_A, ALU_B, ALU_Sel,
      output ALU_Out, ALU_Zero,
      input  rsp_valid, rsp_data, rsp_zero,
      output rsp_ready,
      input  op_count, busy
   );

endinterface

// File: rtl/alu_8_bit.sv
// Standalone combinational 8-bit ALU; carry/borrow are discarded.
module ALU_8_bit
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [2:0]        ALU_Sel,
   output logic [DATA_W-1:0] ALU_Out,
   output logic              Zero
);

   always_comb begin
      ALU_Out = '0;
      case (ALU_Sel)
         ALU_ADD: ALU_Out = A + B;
         ALU_SUB: ALU_Out = A - B;
         ALU_AND: ALU_Out = A & B;
         ALU_OR:  ALU_Out = A | B;
         ALU_XOR: ALU_Out = A ^ B;
         ALU_NOT: ALU_Out = ~A;
         ALU_SHL: ALU_Out = {A[DATA_W-2:0], 1'b0};
         ALU_SHR: ALU_Out = {1'b0, A[DATA_W-1:1]};
         default: ALU_Out = '0;
      endcase
   end

   assign Zero = (ALU_Out == '0);

endmodule

// File: rtl/alu_cmd_sequencer_regfile.sv
// Register file with two asynchronous read ports and one write port;
// every entry clears on reset so it is built from flops.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            regs_q[gi] <= '0;
         end else if (we && (waddr == REG_AW'(gi))) begin
            regs_q[gi] <= wdata;
         end
      end
   end

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts ALU commands, feeds register operands to an external ALU for one
// cycle, captures the result, optionally writes it back and returns it.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   alu_cmd_sequencer_if.slave  bus
);

   state_t            state_q, state_d;
   logic [2:0]        op_q;
   logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
   logic              wr_en_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_zero_q;
   logic [CNT_W-1:0]  op_count_q;

   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

   logic cmd_fire, rsp_fire;

   assign cmd_fire = (state_q == IDLE) && bus.cmd_valid;
   assign rsp_fire = (state_q == RESP) && bus.rsp_ready;

   alu_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (rs1_q),
      .rdata_a (rf_rdata_a),
      .raddr_b (rs2_q),
      .rdata_b (rf_rdata_b)
   );

   // Loads only happen in IDLE and write-back only in EXEC, so one write port suffices.
   always_comb begin
      state_d     = state_q;
      bus.cmd_ready = 1'b0;
      bus.ld_ready  = 1'b0;
      bus.ALU_A     = '0;
      bus.ALU_B     = '0;
      bus.ALU_Sel   = '0;
      rf_we       = 1'b0;
      rf_waddr    = bus.ld_addr;
      rf_wdata    = bus.ld_data;
      case (state_q)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            bus.ld_ready  = 1'b1;
            rf_we         = bus.ld_valid;
            if (bus.cmd_valid) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            bus.ALU_A   = rf_rdata_a;
            bus.ALU_B   = rf_rdata_b;
            bus.ALU_Sel = op_q;
            rf_we       = wr_en_q;
            rf_waddr    = rd_q;
            rf_wdata    = bus.ALU_Out;
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         wr_en_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (cmd_fire) begin
            op_q    <= bus.cmd_op;
            rs1_q   <= bus.cmd_rs1;
            rs2_q   <= bus.cmd_rs2;
            rd_q    <= bus.cmd_rd;
            wr_en_q <= bus.cmd_wr_en;
         end
         if (state_q == EXEC) begin
            rsp_data_q <= bus.ALU_Out;
            rsp_zero_q <= bus.ALU_Zero;
         end
         if (rsp_fire) begin
            op_count_q <= op_count_q + 1'b1;
         end
      end
   end

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised bench for alu_cmd_sequencer with the ALU alongside it,
// checked against an array-based register/ALU model.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.CNT_W(CNT_W)) bus ();

   alu_cmd_sequencer #(.NUM_REGS(8), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ALU_8_bit u_alu (
      .A       (bus.ALU_A),
      .B       (bus.ALU_B),
      .ALU_Sel (bus.ALU_Sel),
      .ALU_Out (bus.ALU_Out),
      .Zero    (bus.ALU_Zero)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] m_regs [8];
   int m_count = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int r;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: r = a * 2;
         default: r = a / 2;
      endcase
      return r[7:0];
   endfunction

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
      check("wait_idle", bus.cmd_ready, 1);
   endtask

   task automatic do_load(input logic [2:0] a, input logic [7:0] d);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_data  = d;
      @(posedge clk);
      @(negedge clk);
      bus.ld_valid = 1'b0;
      m_regs[a] = d;
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [2:0] rd, input logic wr, input logic ld_en,
                          input logic [2:0] la, input logic [7:0] ld, input int hold);
      logic [7:0] a, b, res;
      logic [CNT_W-1:0] exp_cnt;
      wait_idle();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_rs1   = rs1;
      bus.cmd_rs2   = rs2;
      bus.cmd_rd    = rd;
      bus.cmd_wr_en = wr;
      bus.ld_valid  = ld_en;
      bus.ld_addr   = la;
      bus.ld_data   = ld;
      if (ld_en) m_regs[la] = ld;
      a   = m_regs[rs1];
      b   = m_regs[rs2];
      res = alu_ref(op, a, b);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      check("exec_busy", bus.busy, 1);
      check("exec_cmd_ready", bus.cmd_ready, 0);
      check("exec_rsp_valid", bus.rsp_valid, 0);
      check("exec_alu_a", bus.ALU_A, a);
      check("exec_alu_b", bus.ALU_B, b);
      check("exec_alu_sel", bus.ALU_Sel, op);
      @(posedge clk);
      @(negedge clk);
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_data", bus.rsp_data, res);
      check("rsp_zero", bus.rsp_zero, (res == 8'h00));
      if (wr) m_regs[rd] = res;
      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = 1'b0;
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = 3'($urandom_range(0, 7));
         bus.cmd_rs1   = 3'($urandom_range(0, 7));
         bus.cmd_rd    = 3'($urandom_range(0, 7));
         bus.cmd_wr_en = 1'b1;
         bus.ld_valid  = 1'b1;
         bus.ld_addr   = 3'($urandom_range(0, 7));
         bus.ld_data   = 8'($urandom_range(0, 255));
         @(posedge clk);
         @(negedge clk);
         check("hold_rsp_valid", bus.rsp_valid, 1);
         check("hold_rsp_data", bus.rsp_data, res);
         check("hold_cmd_ready", bus.cmd_ready, 0);
         check("hold_ld_ready", bus.ld_ready, 0);
      end
      bus.cmd_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      m_count++;
      exp_cnt = CNT_W'(m_count);
      check("idle_cmd_ready", bus.cmd_ready, 1);
      check("op_count", bus.op_count, exp_cnt);
      $display("cmd op=%0d rs1=%0d rs2=%0d rd=%0d wr=%0d ld=%0d -> %02h cnt=%0d",
               op, rs1, rs2, rd, wr, ld_en, res, exp_cnt);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_rs1   = '0;
      bus.cmd_rs2   = '0;
      bus.cmd_rd    = '0;
      bus.cmd_wr_en = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.ld_addr   = '0;
      bus.ld_data   = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_zero", bus.rsp_zero, 0);
      check("rst_op_count", bus.op_count, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_alu_a", bus.ALU_A, 0);
      check("rst_alu_b", bus.ALU_B, 0);
      check("rst_alu_sel", bus.ALU_Sel, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_ld_ready", bus.ld_ready, 1);

      // Directed cases
      do_load(3'd1, 8'h0F);
      do_load(3'd2, 8'h01);
      run_cmd(ALU_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 3'd0, 8'h00, 0);
      run_cmd(ALU_SUB, 3'd2, 3'd2, 3'd4, 1'b1, 1'b0, 3'd0, 8'h00, 0);
      do_load(3'd6, 8'hFF);
      run_cmd(ALU_ADD, 3'd6, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 0);
      run_cmd(ALU_NOT, 3'd5, 3'd0, 3'd7, 1'b1, 1'b1, 3'd5, 8'hAA, 0);
      run_cmd(ALU_XOR, 3'd3, 3'd7, 3'd3, 1'b1, 1'b0, 3'd0, 8'h00, 5);
      run_cmd(ALU_OR,  3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 0);

      // Asynchronous reset while a response is pending
      wait_idle();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = ALU_ADD;
      bus.cmd_rs1   = 3'd1;
      bus.cmd_rs2   = 3'd1;
      bus.cmd_rd    = 3'd2;
      bus.cmd_wr_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      #2;
      check("pre_rst_rsp_valid", bus.rsp_valid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_op_count", bus.op_count, 0);
      check("mid_rst_rsp_data", bus.rsp_data, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_count = 0;
      for (int i = 1; i < 5; i++)
         run_cmd(ALU_OR, 3'(i), 3'(i), 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 0);

      // Random traffic, enough to wrap the completion counter
      while (m_count < (1 << CNT_W)) begin
         if ($urandom_range(0, 3) == 0)
            do_load(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), $urandom_range(0, 2));
      end
      check("op_count_wrap", bus.op_count, 0);

      // Shifts without write-back leave rd untouched
      do_load(3'd6, 8'h81);
      do_load(3'd7, 8'h3C);
      run_cmd(ALU_SHL, 3'd6, 3'd0, 3'd7, 1'b0, 1'b0, 3'd0, 8'h00, 0);
      check("shl_result", bus.rsp_data, 8'h02);
      run_cmd(ALU_SHR, 3'd6, 3'd0, 3'd7, 1'b0, 1'b0, 3'd0, 8'h00, 0);
      check("shr_result", bus.rsp_data, 8'h40);
      run_cmd(ALU_OR, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 0);
      check("rd_unchanged", bus.rsp_data, 8'h3C);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
